// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants and types for the cache miss fill engine.
// Address fields: [15:11] tag, [10:4] index, [3:1] word, [0] byte.
package cache_pkg;

  localparam int ADDR_W        = 16;
  localparam int DATA_W        = 16;
  localparam int NUM_BLOCKS    = 128;
  localparam int WORDS_PER_BLK = 8;

  localparam int INDEX_W = 7;
  localparam int WORD_W  = 3;
  localparam int TAG_W   = 5;

  localparam int TAG_LSB   = 11;
  localparam int TAG_MSB   = 15;
  localparam int INDEX_LSB = 4;
  localparam int INDEX_MSB = 10;
  localparam int WORD_LSB  = 1;
  localparam int WORD_MSB  = 3;

  typedef enum logic {
    IDLE,
    FILL
  } fill_state_t;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Miss request, memory read channel and data/tag array write bus.
// The fsm modport is the fill engine; env is the surrounding cache/memory.
interface cache_fill_fsm_if;
  import cache_pkg::*;

  logic                  miss_detected;
  logic [ADDR_W-1:0]     miss_address;
  logic [DATA_W-1:0]     memory_data;
  logic                  memory_data_valid;
  logic                  fsm_busy;
  logic                  memory_read;
  logic [ADDR_W-1:0]     memory_address;
  logic                  write_data_array;
  logic [NUM_BLOCKS-1:0] block_enable;
  logic [WORDS_PER_BLK-1:0] word_enable;
  logic [DATA_W-1:0]     data_out;
  logic                  write_tag_array;
  logic [TAG_W-1:0]      tag_out;

  modport fsm (
    input  miss_detected,
    input  miss_address,
    input  memory_data,
    input  memory_data_valid,
    output fsm_busy,
    output memory_read,
    output memory_address,
    output write_data_array,
    output block_enable,
    output word_enable,
    output data_out,
    output write_tag_array,
    output tag_out
  );

  modport env (
    output miss_detected,
    output miss_address,
    output memory_data,
    output memory_data_valid,
    input  fsm_busy,
    input  memory_read,
    input  memory_address,
    input  write_data_array,
    input  block_enable,
    input  word_enable,
    input  data_out,
    input  write_tag_array,
    input  tag_out
  );

endinterface

// File: rtl/cache_fill_fsm_decoder.sv
// Binary to one-hot decoder; output is all-zero when en is low.
module onehot_decoder #(
  parameter int N = 3
) (
  input  logic              en,
  input  logic [N-1:0]      bin,
  output logic [(1<<N)-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[bin] = 1'b1;
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Block fill engine: issues 8 word reads per miss and writes each
// returned beat into the data array, tagging the set on the last beat.
module cache_fill_fsm (
  input  logic         clk,
  input  logic         rst,
  cache_fill_fsm_if.fsm bus
);
  import cache_pkg::*;

  fill_state_t        state_q, state_d;
  logic [15:4]        base_addr_q, base_addr_d;
  logic [3:0]         issue_cnt_q, issue_cnt_d;
  logic [2:0]         recv_cnt_q, recv_cnt_d;

  logic               busy;
  logic               rd;
  logic [ADDR_W-1:0]  rd_addr;
  logic               wr_en;
  logic               tag_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_addr_q <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_addr_q <= base_addr_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  // Outputs are held quiet during reset so a mid-fill reset never strobes.
  always_comb begin
    state_d     = state_q;
    base_addr_d = base_addr_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    busy        = 1'b0;
    rd          = 1'b0;
    rd_addr     = '0;
    wr_en       = 1'b0;
    tag_wr      = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (bus.miss_detected) begin
            state_d     = FILL;
            base_addr_d = bus.miss_address[15:4];
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
          end
        end
        FILL: begin
          busy = 1'b1;
          if (issue_cnt_q < 4'd8) begin
            rd          = 1'b1;
            rd_addr     = {base_addr_q, issue_cnt_q[2:0], 1'b0};
            issue_cnt_d = issue_cnt_q + 4'd1;
          end
          if (bus.memory_data_valid) begin
            wr_en      = 1'b1;
            recv_cnt_d = recv_cnt_q + 3'd1;
            if (recv_cnt_q == 3'd7) begin
              tag_wr  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  onehot_decoder #(.N(INDEX_W)) u_blk_dec (
    .en     (wr_en),
    .bin    (base_addr_q[INDEX_MSB:INDEX_LSB]),
    .onehot (bus.block_enable)
  );

  onehot_decoder #(.N(WORD_W)) u_word_dec (
    .en     (wr_en),
    .bin    (recv_cnt_q),
    .onehot (bus.word_enable)
  );

  assign bus.fsm_busy         = busy;
  assign bus.memory_read      = rd;
  assign bus.memory_address   = rd_addr;
  assign bus.write_data_array = wr_en;
  assign bus.data_out         = bus.memory_data;
  assign bus.write_tag_array  = tag_wr;
  assign bus.tag_out          = base_addr_q[TAG_MSB:TAG_LSB];

endmodule
